// File: rtl/floating_point_multiplier.sv
// Multi-cycle IEEE-754 binary32 multiplier.
// A shift-add core builds the exact 24x24 significand product over
// 24/BITS_PER_CYCLE cycles. The product is then normalised (or denormalised
// when tiny) and truncated. Guard/round/sticky bits go to the rounding stage.
//
// Handshake: the block takes data_valid_i only while idle_o=1. There is no
// backpressure and no queueing. data_valid_o is a one-cycle strobe, and
// result/flags are zero on every other cycle.
module floating_point_multiplier #(
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] multiplicand_i,
   input  logic [31:0] multiplier_i,
   input  logic        data_valid_i,
   output logic        idle_o,
   output logic        data_valid_o,
   output logic        invalid_operation_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic [2:0]  round_bits_o,
   output logic [31:0] result_o
);

   localparam int N = 24 / BITS_PER_CYCLE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULTIPLY,
      S_NORMALIZE,
      S_SPECIAL_VALUES
   } state_t;

   state_t             state_q;
   logic               sign_q;
   logic signed [9:0]  e_q;
   logic               zero_a_q, inf_a_q, qnan_a_q, snan_a_q;
   logic               zero_b_q, inf_b_q, qnan_b_q, snan_b_q;
   logic [47:0]        mcand_q;
   logic [23:0]        mplier_q;
   logic [47:0]        p_q;
   logic [4:0]         cnt_q;

   logic               idle_q, valid_q, invalid_q, overflow_q, underflow_q;
   logic [2:0]         round_bits_q;
   logic [31:0]        result_q;

   // Operand decode of the inputs, used at accept time
   logic [7:0]  exp_a, exp_b, eff_a, eff_b;
   logic [22:0] man_a, man_b;
   logic        zero_a_d, inf_a_d, qnan_a_d, snan_a_d;
   logic        zero_b_d, inf_b_d, qnan_b_d, snan_b_d;
   logic [9:0]  e_d;
   logic        special_d;

   // Classify both incoming operands and form the biased product exponent
   always_comb begin
      exp_a     = multiplicand_i[30:23];
      exp_b     = multiplier_i[30:23];
      man_a     = multiplicand_i[22:0];
      man_b     = multiplier_i[22:0];
      eff_a     = (exp_a == 8'd0) ? 8'd1 : exp_a;
      eff_b     = (exp_b == 8'd0) ? 8'd1 : exp_b;
      zero_a_d  = (exp_a == 8'd0) && (man_a == 23'd0);
      zero_b_d  = (exp_b == 8'd0) && (man_b == 23'd0);
      inf_a_d   = (exp_a == 8'hFF) && (man_a == 23'd0);
      inf_b_d   = (exp_b == 8'hFF) && (man_b == 23'd0);
      qnan_a_d  = (exp_a == 8'hFF) && man_a[22];
      qnan_b_d  = (exp_b == 8'hFF) && man_b[22];
      snan_a_d  = (exp_a == 8'hFF) && !man_a[22] && (man_a != 23'd0);
      snan_b_d  = (exp_b == 8'hFF) && !man_b[22] && (man_b != 23'd0);
      e_d       = {2'b00, eff_a} + {2'b00, eff_b} - 10'd127;
      special_d = zero_a_d | inf_a_d | qnan_a_d | snan_a_d |
                  zero_b_d | inf_b_d | qnan_b_d | snan_b_d;
   end

   // One shift-add step: add the multiplicand times the low multiplier digit
   logic [47:0] p_d;
   always_comb begin
      p_d = p_q;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (mplier_q[j]) p_d = p_d + (mcand_q << j);
      end
   end

   // Leading-zero count of the finished product
   logic [5:0] lz_d;
   always_comb begin
      lz_d = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (p_q[i]) lz_d = 6'(47 - i);
      end
   end

   // Normalise / denormalise the product and truncate to binary32
   logic [47:0]        nm, dn, lost_mask;
   logic signed [10:0] ef, s_full;
   logic [5:0]         s_sh;
   logic               lost;
   logic [31:0]        norm_result_d;
   logic [2:0]         norm_rb_d;
   logic               norm_ovf_d, norm_unf_d;
   always_comb begin
      nm            = p_q << lz_d;
      ef            = $signed({e_q[9], e_q}) + 11'sd1 - $signed({5'b00000, lz_d});
      s_full        = 11'sd1 - ef;
      s_sh          = (s_full > 11'sd26) ? 6'd26 : s_full[5:0];
      dn            = nm >> s_sh;
      lost_mask     = (48'd1 << s_sh) - 48'd1;
      lost          = |(nm & lost_mask);
      norm_ovf_d    = 1'b0;
      norm_unf_d    = 1'b0;
      norm_result_d = 32'd0;
      norm_rb_d     = 3'b000;
      if (ef >= 11'sd255) begin
         norm_ovf_d    = 1'b1;
         norm_result_d = {sign_q, 8'hFF, 23'd0};
      end else if (ef >= 11'sd1) begin
         norm_result_d = {sign_q, ef[7:0], nm[46:24]};
         norm_rb_d     = {nm[23], nm[22], |nm[21:0]};
      end else begin
         norm_unf_d    = 1'b1;
         norm_result_d = {sign_q, 8'd0, dn[46:24]};
         norm_rb_d     = {dn[23], dn[22], (|dn[21:0]) | lost};
      end
   end

   logic unused_bits;
   assign unused_bits = ^{nm[47], dn[47]};

   // Special-operand results in priority order: NaN, inf*zero, inf, zero
   logic [31:0] spec_result_d;
   logic        spec_invalid_d;
   always_comb begin
      spec_result_d  = 32'd0;
      spec_invalid_d = 1'b0;
      if (qnan_a_q | snan_a_q | qnan_b_q | snan_b_q) begin
         spec_result_d  = 32'h7FC00000;
         spec_invalid_d = snan_a_q | snan_b_q;
      end else if ((inf_a_q & zero_b_q) | (inf_b_q & zero_a_q)) begin
         spec_result_d  = 32'h7FC00000;
         spec_invalid_d = 1'b1;
      end else if (inf_a_q | inf_b_q) begin
         spec_result_d  = {sign_q, 8'hFF, 23'd0};
      end else begin
         spec_result_d  = {sign_q, 31'd0};
      end
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         sign_q       <= 1'b0;
         e_q          <= '0;
         zero_a_q     <= 1'b0;
         inf_a_q      <= 1'b0;
         qnan_a_q     <= 1'b0;
         snan_a_q     <= 1'b0;
         zero_b_q     <= 1'b0;
         inf_b_q      <= 1'b0;
         qnan_b_q     <= 1'b0;
         snan_b_q     <= 1'b0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         p_q          <= '0;
         cnt_q        <= '0;
         idle_q       <= 1'b1;
         valid_q      <= 1'b0;
         invalid_q    <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         round_bits_q <= 3'b000;
         result_q     <= 32'd0;
      end else begin
         valid_q      <= 1'b0;
         invalid_q    <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         round_bits_q <= 3'b000;
         result_q     <= 32'd0;
         case (state_q)
            S_IDLE: begin
               if (data_valid_i) begin
                  sign_q   <= multiplicand_i[31] ^ multiplier_i[31];
                  e_q      <= $signed(e_d);
                  zero_a_q <= zero_a_d;
                  inf_a_q  <= inf_a_d;
                  qnan_a_q <= qnan_a_d;
                  snan_a_q <= snan_a_d;
                  zero_b_q <= zero_b_d;
                  inf_b_q  <= inf_b_d;
                  qnan_b_q <= qnan_b_d;
                  snan_b_q <= snan_b_d;
                  mcand_q  <= {24'd0, (exp_a != 8'd0), man_a};
                  mplier_q <= {(exp_b != 8'd0), man_b};
                  p_q      <= '0;
                  cnt_q    <= '0;
                  idle_q   <= 1'b0;
                  state_q  <= special_d ? S_SPECIAL_VALUES : S_MULTIPLY;
               end
            end
            S_MULTIPLY: begin
               p_q      <= p_d;
               mcand_q  <= mcand_q << BITS_PER_CYCLE;
               mplier_q <= mplier_q >> BITS_PER_CYCLE;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'(N - 1)) state_q <= S_NORMALIZE;
            end
            S_NORMALIZE: begin
               valid_q      <= 1'b1;
               overflow_q   <= norm_ovf_d;
               underflow_q  <= norm_unf_d;
               round_bits_q <= norm_rb_d;
               result_q     <= norm_result_d;
               idle_q       <= 1'b1;
               state_q      <= S_IDLE;
            end
            S_SPECIAL_VALUES: begin
               valid_q   <= 1'b1;
               invalid_q <= spec_invalid_d;
               result_q  <= spec_result_d;
               idle_q    <= 1'b1;
               state_q   <= S_IDLE;
            end
            default: begin
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign idle_o              = idle_q;
   assign data_valid_o        = valid_q;
   assign invalid_operation_o = invalid_q;
   assign overflow_o          = overflow_q;
   assign underflow_o         = underflow_q;
   assign round_bits_o        = round_bits_q;
   assign result_o            = result_q;

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Testbench for floating_point_multiplier. It checks the DUT against a
// value-level binary32 multiply model, using directed and randomised operands.
module tb_floating_point_multiplier;

   localparam int BPC = 2;
   localparam int N   = 24 / BPC;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] multiplicand_i = 32'd0;
   logic [31:0] multiplier_i = 32'd0;
   logic        data_valid_i = 1'b0;
   logic        idle_o, data_valid_o, invalid_operation_o, overflow_o, underflow_o;
   logic [2:0]  round_bits_o;
   logic [31:0] result_o;

   always #5 clk = ~clk;

   floating_point_multiplier #(.BITS_PER_CYCLE(BPC)) dut (
      .clk_i               (clk),
      .rst_n_i             (rst_n),
      .multiplicand_i      (multiplicand_i),
      .multiplier_i        (multiplier_i),
      .data_valid_i        (data_valid_i),
      .idle_o              (idle_o),
      .data_valid_o        (data_valid_o),
      .invalid_operation_o (invalid_operation_o),
      .overflow_o          (overflow_o),
      .underflow_o         (underflow_o),
      .round_bits_o        (round_bits_o),
      .result_o            (result_o)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_pass = 0;
   logic [37:0] exp_q[$];   // {result, invalid, overflow, underflow, g, r, s}

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic bit_at(input logic [63:0] v, input int i);
      if (i < 0 || i > 63) return 1'b0;
      return v[i];
   endfunction

   // Returns {special_path, result, invalid, overflow, underflow, g, r, s}.
   // The product is formed as exact integer arithmetic on the value:
   // value = siga*sigb * 2^(effa+effb-254-46).
   function automatic logic [38:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
      logic [7:0]  ea, eb;
      logic [22:0] ma, mb, mant;
      logic        sgn, za, zb, ia, ib, na, nb, sna, snb, g, r, st;
      logic [63:0] prod, sh;
      int          m, effa, effb, big_e, k, s;
      ea  = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
      sgn = a[31] ^ b[31];
      za  = (ea == 0) && (ma == 0);     zb  = (eb == 0) && (mb == 0);
      ia  = (ea == 8'hFF) && (ma == 0); ib  = (eb == 8'hFF) && (mb == 0);
      na  = (ea == 8'hFF) && (ma != 0); nb  = (eb == 8'hFF) && (mb != 0);
      sna = na && !ma[22];              snb = nb && !mb[22];
      if (na || nb) return {1'b1, 32'h7FC00000, sna || snb, 2'b00, 3'b000};
      if ((ia && zb) || (ib && za)) return {1'b1, 32'h7FC00000, 1'b1, 2'b00, 3'b000};
      if (ia || ib) return {1'b1, sgn, 8'hFF, 23'd0, 3'b000, 3'b000};
      if (za || zb) return {1'b1, sgn, 31'd0, 3'b000, 3'b000};
      effa = (ea == 0) ? 1 : int'(ea);
      effb = (eb == 0) ? 1 : int'(eb);
      prod = 64'({ea != 0, ma}) * 64'({eb != 0, mb});
      m = 0;
      for (int i = 0; i < 64; i++) if (prod[i]) m = i;
      big_e = m + effa + effb - 173;
      if (big_e >= 255) return {1'b0, sgn, 8'hFF, 23'd0, 1'b0, 1'b1, 1'b0, 3'b000};
      if (big_e >= 1) begin
         sh = prod << (63 - m);
         return {1'b0, sgn, 8'(big_e), sh[62:40], 3'b000, sh[39], sh[38], |sh[37:0]};
      end
      // Tiny: subnormal field = floor(value * 2^149) = prod * 2^k
      k = effa + effb - 151;
      g = 1'b0; r = 1'b0; st = 1'b0;
      if (k >= 0) mant = 23'(prod << k);
      else begin
         s    = -k;
         mant = (s >= 64) ? 23'd0 : 23'(prod >> s);
         g    = bit_at(prod, s - 1);
         r    = bit_at(prod, s - 2);
         for (int i = 0; i < 64; i++) if (i < s - 2 && prod[i]) st = 1'b1;
      end
      return {1'b0, sgn, 8'd0, mant, 1'b0, 1'b0, 1'b1, g, r, st};
   endfunction

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (data_valid_o) begin
               chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0)
                  chk("result", {result_o, invalid_operation_o, overflow_o, underflow_o, round_bits_o},
                      exp_q.pop_front());
               chk("idle_with_valid", idle_o, 1);
            end else begin
               chk("quiet_outputs", {result_o, invalid_operation_o, overflow_o, underflow_o, round_bits_o}, 0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int w = 0;
      @(negedge clk);
      while (!idle_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("idle_wait", idle_o, 1);
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [38:0] m;
      int          lat;
      m = fmul_model(a, b);
      wait_idle();
      multiplicand_i = a;
      multiplier_i   = b;
      data_valid_i   = 1'b1;
      exp_q.push_back(m[37:0]);
      @(posedge clk);
      #1;
      data_valid_i = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!data_valid_o && lat < 60);
      chk({tag, "_latency"}, lat, m[38] ? 1 : N + 1);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [7:0]  e;
      logic [22:0] man;
      man = 23'($urandom);
      case ($urandom_range(0, 9))
         0: begin e = 8'd0; man = 23'd0; end
         1: begin e = 8'hFF; man = 23'd0; end
         2: begin e = 8'hFF; if (man == 0) man = 23'd1; end
         3: e = 8'd0;
         4: e = 8'($urandom_range(235, 254));
         5: e = 8'($urandom_range(1, 25));
         6: e = 8'($urandom_range(90, 130));
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom), e, man};
   endfunction

   // ---------------- main stimulus ----------------
   logic [31:0] pa[9], pb[9];
   logic [38:0] pe[9];
   int          seen;

   initial begin
      pa = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000,
             32'h00000001, 32'h7F800000, 32'h7F800001, 32'h7FC00001};
      pb = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h40000000, 32'h3F000000,
             32'h3F000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
      pe = '{{1'b0, 32'h40400000, 3'b000, 3'b000},
             {1'b0, 32'h3F800002, 3'b000, 3'b001},
             {1'b0, 32'h7F800000, 3'b010, 3'b000},
             {1'b0, 32'hFF800000, 3'b010, 3'b000},
             {1'b0, 32'h00400000, 3'b001, 3'b000},
             {1'b0, 32'h00000000, 3'b001, 3'b100},
             {1'b1, 32'h7FC00000, 3'b100, 3'b000},
             {1'b1, 32'h7FC00000, 3'b100, 3'b000},
             {1'b1, 32'h7FC00000, 3'b000, 3'b000}};

      // Model pinned to hand-computed values
      for (int i = 0; i < 9; i++) chk($sformatf("model_%0d", i), fmul_model(pa[i], pb[i]), pe[i]);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_idle", idle_o, 1);
      chk("reset_outputs", {data_valid_o, result_o, invalid_operation_o, overflow_o, underflow_o, round_bits_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 9; i++) do_op(pa[i], pb[i], $sformatf("dir_%0d", i));

      // Abort by reset in cycle 5 of an operation
      wait_idle();
      multiplicand_i = 32'h3FC00000;
      multiplier_i   = 32'h40000000;
      data_valid_i   = 1'b1;
      @(posedge clk);
      #1;
      data_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_idle", idle_o, 1);
      chk("abort_valid", data_valid_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (N + 6) begin
         @(posedge clk);
         #1;
         if (data_valid_o) seen++;
      end
      chk("abort_no_result", seen, 0);

      // Second data_valid_i during MULTIPLY must be ignored
      wait_idle();
      multiplicand_i = 32'h40490FDB;
      multiplier_i   = 32'hC0000000;
      data_valid_i   = 1'b1;
      exp_q.push_back(fmul_model(32'h40490FDB, 32'hC0000000) ^ 39'd0);
      @(posedge clk);
      #1;
      data_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      multiplicand_i = 32'h3F800000;
      multiplier_i   = 32'h00000000;
      data_valid_i   = 1'b1;
      @(negedge clk);
      data_valid_i = 1'b0;
      seen = 0;
      repeat (3 * N) begin
         @(posedge clk);
         #1;
         if (data_valid_o) seen++;
      end
      chk("single_result", seen, 1);

      // Randomised operands, back-to-back
      for (int t = 0; t < 250; t++) do_op(rand_operand(), rand_operand(), "rnd");

      repeat (4) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

endmodule

// File: doc/floating_point_multiplier.md
Name: floating_point_multiplier

Overview:
Multi-cycle IEEE-754 binary32 multiplier for the FPU. It is the inverse-operation companion of the floating-point divider and has the same result, flag and round-bit interface toward the downstream rounding stage. The 24x24 mantissa product is built by an iterative shift-add core controlled by an FSM. Results are normalized, or denormalized when tiny, and truncated. Rounding is done downstream from round_bits_o.

Parameters:
BITS_PER_CYCLE, 2, multiplier bits consumed per MULTIPLY cycle; legal values are 1, 2, 3, 4, 6, 8, 12 and 24. N = 24/BITS_PER_CYCLE.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
multiplicand_i  in  32  float32_t operand A
multiplier_i  in  32  float32_t operand B
data_valid_i  in  1  operands valid; sampled only while idle_o=1
idle_o  out  1  FSM in IDLE; ready to accept
data_valid_o  out  1  one-cycle result strobe
invalid_operation_o  out  1  invalid flag, qualified by data_valid_o
overflow_o  out  1  overflow flag
underflow_o  out  1  underflow flag
round_bits_o  out  3  round_bits_t {guard, round, sticky}
result_o  out  32  float32_t truncated result

Behaviour:
- Reset: asynchronous, active-low; state goes to IDLE. All outputs are registered and reset to 0, except idle_o, which resets to 1. Asserting reset mid-operation aborts the operation; no data_valid_o is produced.
- Accept: when data_valid_i=1 in IDLE, latch the following:
  - sign = sA ^ sB.
  - Effective exponent: the exponent field, or 1 if the field is 0.
  - Hidden bit = (exponent field != 0).
  - e = effA + effB - 127, held as a 10-bit signed value.
  - Classification flags for each operand: zero, inf, qNaN, sNaN.
- data_valid_i in any other state is ignored; there is no queueing.
- FSM states: IDLE, MULTIPLY, NORMALIZE, SPECIAL_VALUES.
  - IDLE -> SPECIAL_VALUES if any operand is zero, inf or NaN.
  - IDLE -> MULTIPLY otherwise.
  - MULTIPLY -> NORMALIZE after N cycles.
  - NORMALIZE -> IDLE.
  - SPECIAL_VALUES -> IDLE.
- MULTIPLY:
  - 48-bit accumulator P is cleared on accept.
  - Each cycle, add the multiplicand significand times the next BITS_PER_CYCLE multiplier bits (LSB first), suitably shifted.
  - An iteration counter runs 0..N-1. After N cycles P holds the exact 24x24 product.
- NORMALIZE (P != 0 is guaranteed here):
  - lz = leading zeros of P (0..47). Nm = P << lz, so bit 47 is 1.
  - ef = e + 1 - lz.
  - Overflow, ef >= 255: result = {sign, 0xFF, 0}, overflow_o=1, round bits 0.
  - Normal, 1 <= ef <= 254: mantissa = Nm[46:24], exponent = ef, guard = Nm[23], round = Nm[22], sticky = |Nm[21:0].
  - Tiny, ef <= 0:
    - s = 1 - ef, saturated at 26. D = Nm >> s.
    - mantissa = D[46:24], exponent 0, guard = D[23], round = D[22].
    - sticky = |D[21:0] OR any bit shifted out below bit 0.
    - underflow_o=1.
- SPECIAL_VALUES (round bits 0, overflow and underflow 0), highest priority first:
  - Either operand NaN: result 0x7FC00000. invalid_operation_o=1 only if either operand is sNaN (mantissa[22]=0).
  - inf x zero, either order: result 0x7FC00000, invalid_operation_o=1.
  - Either operand inf: result {sign, 0xFF, 0}.
  - Either operand zero: result {sign, 0, 0}.
- Latency: accept in cycle 0.
  - Normal path: data_valid_o is high in cycle N+2, which is cycle 14 at the default parameter.
  - Special path: data_valid_o is high in cycle 2.
  - idle_o returns to 1 in the same cycle data_valid_o pulses, so back-to-back accepts are possible.
- Flags and result are valid only while data_valid_o=1 and read 0 otherwise.
- Subnormal inputs need no special casing: the hidden bit is 0 and the lz normalization absorbs it.

Test Plan:
- 0x3FC00000 x 0x40000000 (1.5 x 2.0), BITS_PER_CYCLE=2 -> result 0x40400000, flags 0, round bits 000, data_valid_o exactly at cycle 14.
- 0x3F800001 x 0x3F800001 -> result 0x3F800002, guard=0, round=0, sticky=1, flags 0.
- 0x7F7FFFFF x 0x40000000 -> result 0x7F800000, overflow_o=1; 0xFF7FFFFF x 0x40000000 -> 0xFF800000, overflow_o=1.
- 0x00800000 x 0x3F000000 -> result 0x00400000, underflow_o=1, round bits 000; 0x00000001 x 0x3F000000 -> result 0x00000000, guard=1, underflow_o=1.
- 0x7F800000 x 0x80000000 -> 0x7FC00000, invalid_operation_o=1, data_valid_o at cycle 2; 0x7F800001 x 0x3F800000 -> 0x7FC00000, invalid_operation_o=1; 0x7FC00001 x 0x3F800000 -> 0x7FC00000, invalid_operation_o=0.
- Reset asserted at cycle 5 of an operation -> no data_valid_o, idle_o=1 immediately. A second data_valid_i pulsed during MULTIPLY is ignored: exactly one result is produced.
